// File: rtl/ultra_sonic_pkg.sv
// Shared types and constants for the ultrasonic echo responder.
// FSM state encoding, register map and status word layout.
package ultra_sonic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } us_state_t;

  localparam logic [1:0] ADDR_ECHO   = 2'd0;
  localparam logic [1:0] ADDR_BURST  = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_DROP_LSB  = 8;
  localparam int STAT_MEAS_LSB  = 16;

  function automatic logic [31:0] pack_status(input logic [15:0] meas,
                                              input logic [7:0]  drop,
                                              input us_state_t   st);
    return {meas, drop, 5'b0, st};
  endfunction

endpackage

// File: rtl/ultra_sonic_down_counter.sv
// Loadable down counter with zero flag; load has priority, decrement stops at zero.
// Result visible one cycle after load/dec; no backpressure.
module ultra_sonic_down_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_all,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!reset_all) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ultra_sonic_echo_sim.sv
// HC-SR04 style responder: qualifies trig_in, waits burst_delay, then drives echo_out for echo_width cycles.
// Register reads return one cycle after read_en; trigger edges arriving while busy are dropped and counted.
module ultra_sonic_echo_sim
  import ultra_sonic_pkg::*;
#(
  parameter int COUNT_WIDTH     = 32,
  parameter int MIN_TRIG_CYCLES = 500,
  parameter int DEFAULT_BURST   = 10000,
  parameter int DEFAULT_ECHO    = 29000,
  parameter int MAX_ECHO_CYCLES = 1900000,
  parameter int HOLDOFF_CYCLES  = 50000
) (
  input  logic        clk,
  input  logic        reset_all,
  input  logic        trig_in,
  output logic        echo_out,
  input  logic [1:0]  addr,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  localparam int HI_W = $clog2(MIN_TRIG_CYCLES + 1);
  localparam logic [HI_W-1:0]        MIN_TRIG  = HI_W'(MIN_TRIG_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] MAX_LOAD  = COUNT_WIDTH'(MAX_ECHO_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] HOLD_LOAD = COUNT_WIDTH'(HOLDOFF_CYCLES - 1);

  us_state_t              state, state_nxt;
  logic [HI_W-1:0]        hi_cnt, hi_nxt;
  logic [COUNT_WIDTH-1:0] echo_width, burst_delay, shadow_echo;
  logic                   enable;
  logic [15:0]            meas_count;
  logic [7:0]             drop_count;
  logic                   trig_prev, trig_rise;
  logic                   echo_nxt;
  logic                   cnt_load, cnt_dec, cnt_zero;
  logic [COUNT_WIDTH-1:0] cnt_val, cnt_count;
  logic                   meas_inc, drop_inc, shadow_ld;
  logic                   clear_cnt;
  logic [31:0]            rd_mux;

  assign trig_rise = trig_in && !trig_prev;
  assign clear_cnt = write_en && (addr == ADDR_STATUS);

  ultra_sonic_down_counter #(.WIDTH(COUNT_WIDTH)) u_cnt (
    .clk      (clk),
    .reset_all(reset_all),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // One counter serves all timed phases; each phase reloads it for its own duration minus one.
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_cnt;
    echo_nxt  = echo_out;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    meas_inc  = 1'b0;
    drop_inc  = 1'b0;
    shadow_ld = 1'b0;
    if (!enable && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
      echo_nxt  = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && trig_in) begin
            state_nxt = ST_TRIG_HI;
            hi_nxt    = HI_W'(1);
          end
        end
        ST_TRIG_HI: begin
          if (trig_in) begin
            if (hi_cnt < MIN_TRIG) hi_nxt = hi_cnt + HI_W'(1);
          end else if (hi_cnt >= MIN_TRIG) begin
            state_nxt = ST_BURST;
            shadow_ld = 1'b1;
            cnt_load  = 1'b1;
            cnt_val   = burst_delay;
          end else begin
            state_nxt = ST_IDLE;
            drop_inc  = 1'b1;
          end
        end
        ST_BURST: begin
          drop_inc = trig_rise;
          if (cnt_zero) begin
            state_nxt = ST_ECHO;
            echo_nxt  = 1'b1;
            cnt_load  = 1'b1;
            cnt_val   = (shadow_echo == '0) ? MAX_LOAD : shadow_echo - COUNT_WIDTH'(1);
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_ECHO: begin
          drop_inc = trig_rise;
          if (cnt_zero) begin
            state_nxt = ST_HOLDOFF;
            echo_nxt  = 1'b0;
            meas_inc  = 1'b1;
            cnt_load  = 1'b1;
            cnt_val   = HOLD_LOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_HOLDOFF: begin
          drop_inc = trig_rise;
          if (cnt_zero) state_nxt = ST_IDLE;
          else          cnt_dec   = 1'b1;
        end
        default: begin
          state_nxt = ST_IDLE;
          echo_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_ECHO:   rd_mux = 32'(echo_width);
      ADDR_BURST:  rd_mux = 32'(burst_delay);
      ADDR_CTRL:   rd_mux = {31'b0, enable};
      ADDR_STATUS: rd_mux = pack_status(meas_count, drop_count, state);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_all) begin
      state       <= ST_IDLE;
      hi_cnt      <= '0;
      echo_out    <= 1'b0;
      trig_prev   <= 1'b0;
      echo_width  <= COUNT_WIDTH'(DEFAULT_ECHO);
      burst_delay <= COUNT_WIDTH'(DEFAULT_BURST);
      shadow_echo <= COUNT_WIDTH'(DEFAULT_ECHO);
      enable      <= 1'b0;
      meas_count  <= '0;
      drop_count  <= '0;
      read_data   <= '0;
    end else begin
      state     <= state_nxt;
      hi_cnt    <= hi_nxt;
      echo_out  <= echo_nxt;
      trig_prev <= trig_in;
      if (shadow_ld) shadow_echo <= echo_width;
      if (write_en) begin
        case (addr)
          ADDR_ECHO:  echo_width  <= write_data[COUNT_WIDTH-1:0];
          ADDR_BURST: burst_delay <= write_data[COUNT_WIDTH-1:0];
          ADDR_CTRL:  enable      <= write_data[0];
          default:    ;
        endcase
      end
      if (clear_cnt) begin
        meas_count <= '0;
        drop_count <= '0;
      end else begin
        if (meas_inc) meas_count <= meas_count + 16'd1;
        if (drop_inc && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
      end
      if (read_en) read_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_ultra_sonic_echo_sim.sv
// Directed plus randomized bench for ultra_sonic_echo_sim against a timing/counter model.
module tb_ultra_sonic_echo_sim;

  localparam int MIN_T = 10;
  localparam int HOLD  = 20;
  localparam int MAXE  = 100;
  localparam int DEF_B = 10000;
  localparam int DEF_E = 29000;
  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        reset_all = 1'b0;
  logic        trig_in = 1'b0;
  logic        echo_out;
  logic [1:0]  addr = 2'd0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;

  // reference model state
  int exp_echo, exp_burst, exp_meas, exp_drop;

  ultra_sonic_echo_sim #(
    .COUNT_WIDTH(32), .MIN_TRIG_CYCLES(MIN_T), .DEFAULT_BURST(DEF_B),
    .DEFAULT_ECHO(DEF_E), .MAX_ECHO_CYCLES(MAXE), .HOLDOFF_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset_all(reset_all), .trig_in(trig_in), .echo_out(echo_out),
    .addr(addr), .read_en(read_en), .write_en(write_en),
    .write_data(write_data), .read_data(read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, expv, expv);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    write_en = 1'b1; addr = a; write_data = d;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    read_en = 1'b1; addr = a;
    @(negedge clk);
    read_en = 1'b0;
    d = read_data;
  endtask

  function automatic logic [31:0] exp_status();
    logic [15:0] m;
    logic [7:0]  dr;
    m  = 16'(exp_meas % 65536);
    dr = 8'(exp_drop);
    return {m, dr, 8'h00};
  endfunction

  function automatic int eff_width(input int ew);
    return (ew == 0) ? MAXE : ew;
  endfunction

  // k counts negedges after the edge that samples trig_in low (k=0).
  task automatic run_meas(input int hi, input int wk, input logic [1:0] wa, input logic [31:0] wd,
                          input int tk, input int rk,
                          output int rise_k, output int width, output logic echo_rst);
    rise_k = -1; width = -1; echo_rst = 1'bx;
    @(negedge clk);
    trig_in = 1'b1;
    repeat (hi) @(negedge clk);
    trig_in = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      write_en = 1'b0;
      if (k == tk + 3) trig_in = 1'b0;
      if (echo_out && rise_k < 0) rise_k = k;
      if (!echo_out && rise_k >= 0 && width < 0) width = k - rise_k;
      if (k == rk + 1) begin
        echo_rst  = echo_out;
        reset_all = 1'b1;
        break;
      end
      if (width >= 0) break;
      if (k == wk) begin write_en = 1'b1; addr = wa; write_data = wd; end
      if (k == tk) trig_in = 1'b1;
      if (k == rk) reset_all = 1'b0;
    end
    write_en = 1'b0;
    trig_in  = 1'b0;
  endtask

  task automatic idle_wait();
    repeat (HOLD + 5) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    rd(2'd3, d);
    chk(tag, d, exp_status());
  endtask

  initial begin
    logic [31:0] d;
    int   rise, wid, bd, ew, hi, r;
    logic er;

    exp_echo = DEF_E; exp_burst = DEF_B; exp_meas = 0; exp_drop = 0;
    repeat (3) @(negedge clk);
    chk("rst_echo_out", {31'b0, echo_out}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    reset_all = 1'b1;
    rd(2'd0, d); chk("rst_echo_width", d, 32'(DEF_E));
    rd(2'd1, d); chk("rst_burst_delay", d, 32'(DEF_B));
    rd(2'd2, d); chk("rst_control", d, 32'd0);
    check_status("rst_status");
    @(negedge clk);
    chk("read_data_hold", read_data, exp_status());

    // 1: basic measurement
    wr(2'd2, 32'd1); wr(2'd1, 32'd5); wr(2'd0, 32'd37);
    exp_burst = 5; exp_echo = 37;
    run_meas(12, -100, 2'd0, 0, -100, -100, rise, wid, er);
    chk("t1_rise", rise, exp_burst + 1);
    chk("t1_width", wid, eff_width(exp_echo));
    exp_meas++;
    idle_wait();
    check_status("t1_status");

    // 2: short trigger dropped, minimum length accepted
    run_meas(9, -100, 2'd0, 0, -100, -100, rise, wid, er);
    chk("t2_no_echo", rise, -1);
    exp_drop++;
    check_status("t2_status");
    run_meas(MIN_T, -100, 2'd0, 0, -100, -100, rise, wid, er);
    chk("t2_min_rise", rise, exp_burst + 1);
    chk("t2_min_width", wid, eff_width(exp_echo));
    exp_meas++;
    idle_wait();

    // 3: echo_width 0 means maximum
    wr(2'd0, 32'd0); exp_echo = 0;
    run_meas(12, -100, 2'd0, 0, -100, -100, rise, wid, er);
    chk("t3_width_max", wid, MAXE);
    exp_meas++;
    idle_wait();

    // 4: write during echo affects next pulse only; retrigger during echo dropped
    wr(2'd0, 32'd37); exp_echo = 37;
    run_meas(12, exp_burst + 6, 2'd0, 32'd50, exp_burst + 11, -100, rise, wid, er);
    chk("t4_width_cur", wid, 37);
    exp_echo = 50; exp_meas++; exp_drop++;
    idle_wait();
    check_status("t4_status");
    run_meas(12, -100, 2'd0, 0, -100, -100, rise, wid, er);
    chk("t4_width_next", wid, 50);
    exp_meas++;
    idle_wait();

    // simultaneous read and write returns the old value
    @(negedge clk);
    write_en = 1'b1; read_en = 1'b1; addr = 2'd1; write_data = 32'd3;
    @(negedge clk);
    write_en = 1'b0; read_en = 1'b0;
    chk("rw_old_value", read_data, 32'(exp_burst));
    exp_burst = 3;
    rd(2'd1, d); chk("rw_new_value", d, 32'd3);

    // 5: reset mid-echo
    run_meas(12, -100, 2'd0, 0, -100, exp_burst + 4, rise, wid, er);
    chk("t5_echo_after_rst", {31'b0, er}, 32'd0);
    chk("t5_read_data_rst", read_data, 32'd0);
    exp_echo = DEF_E; exp_burst = DEF_B; exp_meas = 0; exp_drop = 0;
    rd(2'd0, d); chk("t5_echo_def", d, 32'(DEF_E));
    rd(2'd1, d); chk("t5_burst_def", d, 32'(DEF_B));
    rd(2'd2, d); chk("t5_ctrl_def", d, 32'd0);
    check_status("t5_status_def");

    // enable cleared mid-burst
    wr(2'd2, 32'd1); wr(2'd1, 32'd8); wr(2'd0, 32'd20);
    exp_burst = 8; exp_echo = 20;
    run_meas(12, 2, 2'd2, 32'd0, -100, -100, rise, wid, er);
    chk("t5_disable_no_echo", rise, -1);
    check_status("t5_disable_status");
    wr(2'd2, 32'd1);

    // 6: counter clear wins over increment
    wr(2'd1, 32'd3); wr(2'd0, 32'd10);
    exp_burst = 3; exp_echo = 10;
    run_meas(12, exp_burst + 1 + 10 - 1, 2'd3, 32'd0, -100, -100, rise, wid, er);
    chk("t6_width", wid, 10);
    exp_meas = 0; exp_drop = 0;
    idle_wait();
    check_status("t6_clear_status");
    rd(2'd2, d); chk("t6_ctrl_read", d, 32'd1);

    // randomized measurements
    for (int i = 0; i < 6; i++) begin
      bd = $urandom_range(0, 12);
      ew = $urandom_range(0, 60);
      hi = $urandom_range(7, 14);
      wr(2'd1, 32'(bd)); wr(2'd0, 32'(ew));
      exp_burst = bd; exp_echo = ew;
      run_meas(hi, -100, 2'd0, 0, -100, -100, rise, wid, er);
      if (hi >= MIN_T) begin
        exp_meas++;
        r = exp_burst + 1;
        chk($sformatf("rnd%0d_rise", i), rise, r);
        chk($sformatf("rnd%0d_width", i), wid, eff_width(exp_echo));
        idle_wait();
      end else begin
        if (exp_drop < 255) exp_drop++;
        chk($sformatf("rnd%0d_no_echo", i), rise, -1);
      end
      check_status($sformatf("rnd%0d_status", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
